mole_round_engine: RTL

Parametrised whack-a-mole round engine, successor to the fixed 8-hole game logic and 30-second timer pair. It owns the round state machine, countdown, mole spawning and expiry, and tap scoring. It supports N holes, difficulty-scaled concurrency and lifetime, pause/resume with state retention, and saturating signed scoring. It sits between the tap decoder and the VGA/score display muxing in the top level.

---
 rtl/mole_round_engine.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mole_round_engine.sv
// Whack-a-mole round engine: round FSM, seconds countdown, LFSR-driven mole
// spawning with difficulty-scaled lifetime and concurrency, and saturating
// tap scoring. Every output comes straight from a flop.
module mole_round_engine #(
  parameter int N_HOLES   = 8,
  parameter int SCORE_W   = 12,
  parameter int GAME_SEC  = 30,
  parameter int TICK_DIV  = 100_000_000,
  parameter int SPAWN_DIV = 25_000_000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               pause,
  input  logic [1:0]         difficulty,
  input  logic [N_HOLES-1:0] tap,
  output logic [N_HOLES-1:0] holes,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         time_left,
  output logic               playing,
  output logic               game_over
);

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SPAWN_W = (SPAWN_DIV > 1) ? $clog2(SPAWN_DIV) : 1;
  // Headroom so hits*(1+d) and misses never wrap the signed intermediate.
  localparam int SUM_W   = SCORE_W + 10;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE, S_OVER} state_e;

  state_e                    state_q, state_d;
  logic [TICK_W-1:0]         tick_q, tick_d;
  logic [SPAWN_W-1:0]        spawn_q, spawn_d;
  logic [7:0]                time_q, time_d;
  logic [SCORE_W-1:0]        score_q, score_d;
  logic [N_HOLES-1:0]        map_q, map_d;
  logic [N_HOLES-1:0][1:0]   age_q, age_d;
  logic [1:0]                diff_q, diff_d;
  logic [15:0]               lfsr_q, lfsr_d;
  logic [N_HOLES-1:0]        holes_q, holes_d;
  logic                      playing_q, playing_d;
  logic                      game_over_q, game_over_d;

  logic                      start_ok, active, tick_wrap, spawn_wrap, round_end;
  logic [7:0]                hit_cnt, miss_cnt, live_cnt, cap, cand_idx;
  logic [N_HOLES-1:0]        expired, live_map, cand_onehot;
  logic [N_HOLES-1:0][1:0]   aged_age;
  logic [2:0]                lifetime;
  logic                      spawn_ok;
  logic [SUM_W-1:0]          gain, sum;
  logic [SCORE_W-1:0]        score_sat;

  assign start_ok   = start && (state_q == S_IDLE || state_q == S_OVER);
  assign active     = (state_q == S_PLAY) && !pause;
  assign tick_wrap  = active && (tick_q == TICK_W'(TICK_DIV - 1));
  assign spawn_wrap = active && (spawn_q == SPAWN_W'(SPAWN_DIV - 1));
  assign round_end  = tick_wrap && (time_q == 8'd1);
  assign lifetime   = 3'd4 - {1'b0, diff_q};
  assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign cand_idx   = lfsr_q[7:0] % 8'(N_HOLES);

  // Classify this cycle's taps against the map as it stands before any expiry.
  always_comb begin
    hit_cnt  = '0;
    miss_cnt = '0;
    for (int i = 0; i < N_HOLES; i++) begin
      if (tap[i] && map_q[i])  hit_cnt  = hit_cnt + 8'd1;
      if (tap[i] && !map_q[i]) miss_cnt = miss_cnt + 8'd1;
    end
  end

  // Spawn-slot aging, expiry, occupancy count and candidate selection.
  always_comb begin
    logic [2:0] new_age;
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    aged_age    = age_q;
    expired     = '0;
    live_cnt    = '0;
    cand_onehot = '0;
    new_age     = '0;
    for (int i = 0; i < N_HOLES; i++) begin
      if (map_q[i]) begin
        new_age = {1'b0, age_q[i]} + 3'd1;
        if (new_age == lifetime) expired[i] = 1'b1;
        else                     aged_age[i] = new_age[1:0];
      end
    end
    live_map = map_q & ~expired;
    // Occupancy is taken after expiry; moles hit this cycle still count.
    for (int i = 0; i < N_HOLES; i++) begin
      if (live_map[i]) live_cnt = live_cnt + 8'd1;
      if (8'(i) == cand_idx) cand_onehot[i] = 1'b1;
    end
    cap = 8'(diff_q) + 8'd1;
    if (cap > 8'(N_HOLES)) cap = 8'(N_HOLES);
    spawn_ok = (live_cnt < cap) && ((cand_onehot & (live_map | tap)) == '0);
  end

  // Net tap delta applied once, saturated to the score range.
  always_comb begin
    gain = SUM_W'(hit_cnt) * SUM_W'({1'b0, diff_q} + 3'd1);
    sum  = SUM_W'(score_q) + gain - SUM_W'(miss_cnt);
    if (sum[SUM_W-1])                 score_sat = '0;
    else if (sum > SUM_W'(SCORE_MAX)) score_sat = SCORE_MAX;
    else                              score_sat = sum[SCORE_W-1:0];
  end

  // Datapath next state: round setup on start, otherwise advance only when active.
  always_comb begin
    tick_d  = tick_q;
    spawn_d = spawn_q;
    time_d  = time_q;
    score_d = score_q;
    map_d   = map_q;
    age_d   = age_q;
    diff_d  = diff_q;
    if (start_ok) begin
      tick_d  = '0;
      spawn_d = '0;
      time_d  = 8'(GAME_SEC);
      score_d = '0;
      map_d   = '0;
      age_d   = '0;
      diff_d  = difficulty;
    end else if (active) begin
      tick_d  = tick_wrap  ? '0 : tick_q + TICK_W'(1);
      spawn_d = spawn_wrap ? '0 : spawn_q + SPAWN_W'(1);
      if (tick_wrap) time_d = time_q - 8'd1;
      score_d = score_sat;
      if (spawn_wrap) begin
        map_d = live_map & ~tap;
        age_d = aged_age;
        if (spawn_ok) begin
          map_d = map_d | cand_onehot;
          for (int i = 0; i < N_HOLES; i++)
            if (cand_onehot[i]) age_d[i] = 2'd0;
        end
      end else begin
        map_d = map_q & ~tap;
      end
      if (round_end) map_d = '0;
    end
  end

  // Round FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_OVER: if (start) state_d = S_PLAY;
      S_PLAY: begin
        if (pause)          state_d = S_PAUSE;
        else if (round_end) state_d = S_OVER;
      end
      S_PAUSE:        if (!pause) state_d = S_PLAY;
      default:        state_d = S_IDLE;
    endcase
  end

  // Output next values, derived from the upcoming state so outputs stay registered.
  always_comb begin
    holes_d     = (state_d == S_PLAY) ? map_d : '0;
    playing_d   = (state_d == S_PLAY) || (state_d == S_PAUSE);
    game_over_d = (state_d == S_OVER) && (state_q != S_OVER);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= S_IDLE;
      tick_q  <= '0;
      spawn_q <= '0;
      time_q  <= 8'(GAME_SEC);
      score_q <= '0;
      map_q   <= '0;
      // NOTE: the small age array is reset too; it is plain flops, not a RAM, so reset costs nothing.
      age_q   <= '0;
      diff_q  <= '0;
      lfsr_q  <= 16'hACE1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      spawn_q <= spawn_d;
      time_q  <= time_d;
      score_q <= score_d;
      map_q   <= map_d;
      age_q   <= age_d;
      diff_q  <= diff_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      holes_q     <= '0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      holes_q     <= holes_d;
      playing_q   <= playing_d;
      game_over_q <= game_over_d;
    end
  end

  assign holes     = holes_q;
  assign score     = score_q;
  assign time_left = time_q;
  assign playing   = playing_q;
  assign game_over = game_over_q;

endmodule
